// File: rtl/multicycle_ctrl_pkg.sv
// Shared core types for the multi-cycle RV32 control path: decoded opcode
// classes, controller states, datapath mux selects and halt causes, plus
// helpers that map an opcode class onto its ALU operand selects.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        OPC_LUI     = 4'd0,
        OPC_AUIPC   = 4'd1,
        OPC_JAL     = 4'd2,
        OPC_JALR    = 4'd3,
        OPC_BRANCH  = 4'd4,
        OPC_LOAD    = 4'd5,
        OPC_STORE   = 4'd6,
        OPC_OP_IMM  = 4'd7,
        OPC_OP      = 4'd8,
        OPC_SYSTEM  = 4'd9,
        OPC_ILLEGAL = 4'd10
    } opcodeType_e;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } ctrlState_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_TARGET = 2'd1,
        PC_ALU    = 2'd2
    } pcSel_e;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } aluASel_e;

    typedef enum logic [0:0] {
        B_RS2 = 1'b0,
        B_IMM = 1'b1
    } aluBSel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wbSel_e;

    typedef enum logic [1:0] {
        HC_NONE    = 2'd0,
        HC_SYSTEM  = 2'd1,
        HC_ILLEGAL = 2'd2,
        HC_TIMEOUT = 2'd3
    } haltCause_e;

    // ALU operand A: PC-relative forms use the PC, LUI adds the immediate to zero.
    function automatic aluASel_e alu_a_sel_for(input opcodeType_e opc);
        aluASel_e sel;
        sel = A_RS1;
        case (opc)
            OPC_AUIPC, OPC_JAL: sel = A_PC;
            OPC_LUI:            sel = A_ZERO;
            default:            sel = A_RS1;
        endcase
        return sel;
    endfunction

    // ALU operand B: register-register forms (OP, BRANCH compare) use rs2.
    function automatic aluBSel_e alu_b_sel_for(input opcodeType_e opc);
        aluBSel_e sel;
        sel = B_RS2;
        case (opc)
            OPC_OP, OPC_BRANCH: sel = B_RS2;
            OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR,
            OPC_AUIPC, OPC_JAL, OPC_LUI: sel = B_IMM;
            default:            sel = B_RS2;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Wait-cycle counter for memory handshakes. Counts consecutive cycles a
// request is outstanding without an ack and raises a one-cycle timeout when
// the count would reach LIMIT. An ack in that same cycle suppresses the
// timeout. LIMIT of 0 disables the timer entirely.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    output logic timeout
);

    localparam int unsigned CW = (LIMIT < 32'd2) ? 32'd1 : $clog2(LIMIT + 32'd1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);
    localparam bit ENABLED = (LIMIT != 32'd0);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_inc_s;
    logic          expire_s;

    // Limit compare against the count this cycle would produce.
    always_comb begin
        cnt_inc_s = cnt_r + CW'(1'b1);
        if (ENABLED && active && !ack && (cnt_inc_s == LIMIT_C)) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
    end

    // Wait counter: clears whenever no request is pending, on ack, or on expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (!ENABLED || !active || ack || expire_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_inc_s;
        end
    end

    assign timeout = expire_s;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32 core. Sequences FETCH, DECODE,
// EXECUTE, MEM and WRITEBACK, drives memory handshakes, PC/IR/regfile
// enables and datapath selects, counts retired instructions and halts on
// SYSTEM, an illegal opcode or a memory timeout.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  opcodeType_e       opcode_type,
    input  logic              branch_taken,
    input  logic              imem_ack,
    input  logic              dmem_ack,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              ir_we,
    output logic              pc_we,
    output pcSel_e            pc_sel,
    output aluASel_e          alu_a_sel,
    output aluBSel_e          alu_b_sel,
    output logic              rf_we,
    output wbSel_e            wb_sel,
    output ctrlState_e        state,
    output logic              halted,
    output haltCause_e        halt_cause,
    output logic [CNT_W-1:0]  instret
);

    ctrlState_e       state_r;
    logic             halted_r;
    haltCause_e       cause_r;
    logic [CNT_W-1:0] instret_r;

    logic             retire_s;
    logic             wait_active_s;
    logic             wait_ack_s;
    logic             timeout_s;

    // Route the handshake of whichever memory is being waited on to the timer.
    always_comb begin
        if (state_r == ST_FETCH) begin
            wait_active_s = 1'b1;
            wait_ack_s    = imem_ack;
        end else if (state_r == ST_MEM) begin
            wait_active_s = 1'b1;
            wait_ack_s    = dmem_ack;
        end else begin
            wait_active_s = 1'b0;
            wait_ack_s    = 1'b0;
        end
    end

    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .active  (wait_active_s),
        .ack     (wait_ack_s),
        .timeout (timeout_s)
    );

    // Output decode from state and opcode; acks only gate the completing cycle.
    // While rst is high everything is forced to its idle encoding.
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        alu_a_sel = A_RS1;
        alu_b_sel = B_RS2;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        retire_s  = 1'b0;
        if (!rst) begin
            case (state_r)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                ST_DECODE: begin
                    imem_req = 1'b0;
                end
                ST_EXECUTE: begin
                    alu_a_sel = alu_a_sel_for(opcode_type);
                    alu_b_sel = alu_b_sel_for(opcode_type);
                    if (opcode_type == OPC_BRANCH) begin
                        pc_we    = 1'b1;
                        pc_sel   = branch_taken ? PC_TARGET : PC_PLUS4;
                        retire_s = 1'b1;
                    end else begin
                        pc_we = 1'b0;
                    end
                end
                ST_MEM: begin
                    alu_a_sel = alu_a_sel_for(opcode_type);
                    alu_b_sel = alu_b_sel_for(opcode_type);
                    dmem_req  = 1'b1;
                    dmem_we   = (opcode_type == OPC_STORE);
                    if (dmem_ack && (opcode_type == OPC_STORE)) begin
                        pc_we    = 1'b1;
                        retire_s = 1'b1;
                    end else begin
                        pc_we = 1'b0;
                    end
                end
                ST_WRITEBACK: begin
                    alu_a_sel = alu_a_sel_for(opcode_type);
                    alu_b_sel = alu_b_sel_for(opcode_type);
                    rf_we     = 1'b1;
                    pc_we     = 1'b1;
                    retire_s  = 1'b1;
                    case (opcode_type)
                        OPC_LOAD:          wb_sel = WB_MEM;
                        OPC_JAL, OPC_JALR: wb_sel = WB_PC4;
                        default:           wb_sel = WB_ALU;
                    endcase
                    case (opcode_type)
                        OPC_JAL:  pc_sel = PC_TARGET;
                        OPC_JALR: pc_sel = PC_ALU;
                        default:  pc_sel = PC_PLUS4;
                    endcase
                end
                ST_HALT: begin
                    imem_req = 1'b0;
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end else begin
            retire_s = 1'b0;
        end
    end

    // Controller state, halt status and retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_FETCH;
            halted_r  <= 1'b0;
            cause_r   <= HC_NONE;
            instret_r <= '0;
        end else begin
            if (retire_s) begin
                instret_r <= instret_r + CNT_W'(1'b1);
            end
            case (state_r)
                ST_FETCH: begin
                    if (imem_ack) begin
                        state_r <= ST_DECODE;
                    end else if (timeout_s) begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                        cause_r  <= HC_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    if (opcode_type == OPC_ILLEGAL) begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                        cause_r  <= HC_ILLEGAL;
                    end else begin
                        state_r <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    case (opcode_type)
                        OPC_BRANCH:           state_r <= ST_FETCH;
                        OPC_LOAD, OPC_STORE:  state_r <= ST_MEM;
                        OPC_SYSTEM: begin
                            state_r  <= ST_HALT;
                            halted_r <= 1'b1;
                            cause_r  <= HC_SYSTEM;
                        end
                        OPC_ILLEGAL: begin
                            state_r  <= ST_HALT;
                            halted_r <= 1'b1;
                            cause_r  <= HC_ILLEGAL;
                        end
                        default:              state_r <= ST_WRITEBACK;
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        state_r <= (opcode_type == OPC_STORE) ? ST_FETCH : ST_WRITEBACK;
                    end else if (timeout_s) begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                        cause_r  <= HC_TIMEOUT;
                    end
                end
                ST_WRITEBACK: begin
                    state_r <= ST_FETCH;
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

    assign state      = state_r;
    assign halted     = halted_r;
    assign halt_cause = cause_r;
    assign instret    = instret_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks representative instructions
// through the FSM and compares each cycle's outputs with hand-derived values.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int unsigned CNT_W = 3;

    logic             clk;
    logic             rst;
    opcodeType_e      opcode_type;
    logic             branch_taken;
    logic             imem_ack;
    logic             dmem_ack;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             ir_we;
    logic             pc_we;
    pcSel_e           pc_sel;
    aluASel_e         alu_a_sel;
    aluBSel_e         alu_b_sel;
    logic             rf_we;
    wbSel_e           wb_sel;
    ctrlState_e       state;
    logic             halted;
    haltCause_e       halt_cause;
    logic [CNT_W-1:0] instret;

    int n_checks;
    int n_fail;

    multicycle_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode_type  (opcode_type),
        .branch_taken (branch_taken),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .state        (state),
        .halted       (halted),
        .halt_cause   (halt_cause),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, settle, then caller checks.
    task automatic cyc(input opcodeType_e o, input logic bt, input logic ia, input logic da);
        @(negedge clk);
        rst          = 1'b0;
        opcode_type  = o;
        branch_taken = bt;
        imem_ack     = ia;
        dmem_ack     = da;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_plain(input opcodeType_e o);
        repeat (4) cyc(o, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        opcode_type  = OPC_OP_IMM;
        branch_taken = 1'b0;
        imem_ack     = 1'b0;
        dmem_ack     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_state",   32'(state),      32'(ST_FETCH));
        check_eq("rst_imemreq", 32'(imem_req),   32'd0);
        check_eq("rst_instret", 32'(instret),    32'd0);
        check_eq("rst_halted",  32'(halted),     32'd0);
        check_eq("rst_cause",   32'(halt_cause), 32'(HC_NONE));

        // addi x8,x9,-1 with acks tied high
        cyc(OPC_OP_IMM, 1'b0, 1'b1, 1'b1);
        check_eq("addi_f_state", 32'(state),    32'(ST_FETCH));
        check_eq("addi_f_req",   32'(imem_req), 32'd1);
        check_eq("addi_f_irwe",  32'(ir_we),    32'd1);
        cyc(OPC_OP_IMM, 1'b0, 1'b1, 1'b1);
        check_eq("addi_d_state", 32'(state),    32'(ST_DECODE));
        check_eq("addi_d_pcwe",  32'(pc_we),    32'd0);
        check_eq("addi_d_req",   32'(imem_req), 32'd0);
        cyc(OPC_OP_IMM, 1'b0, 1'b1, 1'b1);
        check_eq("addi_e_state", 32'(state),     32'(ST_EXECUTE));
        check_eq("addi_e_asel",  32'(alu_a_sel), 32'(A_RS1));
        check_eq("addi_e_bsel",  32'(alu_b_sel), 32'(B_IMM));
        check_eq("addi_e_rfwe",  32'(rf_we),     32'd0);
        cyc(OPC_OP_IMM, 1'b0, 1'b1, 1'b1);
        check_eq("addi_w_state", 32'(state),   32'(ST_WRITEBACK));
        check_eq("addi_w_rfwe",  32'(rf_we),   32'd1);
        check_eq("addi_w_wbsel", 32'(wb_sel),  32'(WB_ALU));
        check_eq("addi_w_pcsel", 32'(pc_sel),  32'(PC_PLUS4));
        check_eq("addi_w_pcwe",  32'(pc_we),   32'd1);
        check_eq("addi_w_iret",  32'(instret), 32'd0);

        // sw x8,1234(x9) with dmem_ack three cycles late
        cyc(OPC_STORE, 1'b0, 1'b1, 1'b0);
        check_eq("sw_f_state", 32'(state),   32'(ST_FETCH));
        check_eq("sw_f_iret",  32'(instret), 32'd1);
        cyc(OPC_STORE, 1'b0, 1'b0, 1'b0);
        cyc(OPC_STORE, 1'b0, 1'b0, 1'b0);
        check_eq("sw_e_bsel", 32'(alu_b_sel), 32'(B_IMM));
        for (int i = 0; i < 3; i++) begin
            cyc(OPC_STORE, 1'b0, 1'b0, 1'b0);
            check_eq("sw_m_req",  32'(dmem_req), 32'd1);
            check_eq("sw_m_we",   32'(dmem_we),  32'd1);
            check_eq("sw_m_pcwe", 32'(pc_we),    32'd0);
        end
        cyc(OPC_STORE, 1'b0, 1'b0, 1'b1);
        check_eq("sw_a_req",   32'(dmem_req), 32'd1);
        check_eq("sw_a_we",    32'(dmem_we),  32'd1);
        check_eq("sw_a_pcwe",  32'(pc_we),    32'd1);
        check_eq("sw_a_pcsel", 32'(pc_sel),   32'(PC_PLUS4));
        check_eq("sw_a_rfwe",  32'(rf_we),    32'd0);
        check_eq("sw_a_iret",  32'(instret),  32'd1);

        // beq taken
        cyc(OPC_BRANCH, 1'b1, 1'b1, 1'b0);
        check_eq("beqt_f_state", 32'(state),   32'(ST_FETCH));
        check_eq("beqt_f_iret",  32'(instret), 32'd2);
        cyc(OPC_BRANCH, 1'b1, 1'b0, 1'b0);
        cyc(OPC_BRANCH, 1'b1, 1'b0, 1'b0);
        check_eq("beqt_e_pcwe",  32'(pc_we),     32'd1);
        check_eq("beqt_e_pcsel", 32'(pc_sel),    32'(PC_TARGET));
        check_eq("beqt_e_rfwe",  32'(rf_we),     32'd0);
        check_eq("beqt_e_bsel",  32'(alu_b_sel), 32'(B_RS2));

        // beq not taken
        cyc(OPC_BRANCH, 1'b0, 1'b1, 1'b0);
        check_eq("beqn_f_iret", 32'(instret), 32'd3);
        cyc(OPC_BRANCH, 1'b0, 1'b0, 1'b0);
        cyc(OPC_BRANCH, 1'b0, 1'b0, 1'b0);
        check_eq("beqn_e_pcwe",  32'(pc_we),  32'd1);
        check_eq("beqn_e_pcsel", 32'(pc_sel), 32'(PC_PLUS4));
        check_eq("beqn_e_rfwe",  32'(rf_we),  32'd0);

        // jal x1,65536
        cyc(OPC_JAL, 1'b0, 1'b1, 1'b0);
        check_eq("jal_f_iret", 32'(instret), 32'd4);
        cyc(OPC_JAL, 1'b0, 1'b0, 1'b0);
        cyc(OPC_JAL, 1'b0, 1'b0, 1'b0);
        check_eq("jal_e_asel", 32'(alu_a_sel), 32'(A_PC));
        cyc(OPC_JAL, 1'b0, 1'b0, 1'b0);
        check_eq("jal_w_state", 32'(state),  32'(ST_WRITEBACK));
        check_eq("jal_w_wbsel", 32'(wb_sel), 32'(WB_PC4));
        check_eq("jal_w_pcsel", 32'(pc_sel), 32'(PC_TARGET));
        check_eq("jal_w_rfwe",  32'(rf_we),  32'd1);

        // lw with immediate ack: five cycles
        cyc(OPC_LOAD, 1'b0, 1'b1, 1'b1);
        check_eq("lw_f_iret", 32'(instret), 32'd5);
        cyc(OPC_LOAD, 1'b0, 1'b1, 1'b1);
        cyc(OPC_LOAD, 1'b0, 1'b1, 1'b1);
        cyc(OPC_LOAD, 1'b0, 1'b1, 1'b1);
        check_eq("lw_m_state", 32'(state),    32'(ST_MEM));
        check_eq("lw_m_req",   32'(dmem_req), 32'd1);
        check_eq("lw_m_we",    32'(dmem_we),  32'd0);
        check_eq("lw_m_pcwe",  32'(pc_we),    32'd0);
        cyc(OPC_LOAD, 1'b0, 1'b1, 1'b1);
        check_eq("lw_w_state", 32'(state),   32'(ST_WRITEBACK));
        check_eq("lw_w_wbsel", 32'(wb_sel),  32'(WB_MEM));
        check_eq("lw_w_rfwe",  32'(rf_we),   32'd1);
        check_eq("lw_w_iret",  32'(instret), 32'd5);

        // jalr
        cyc(OPC_JALR, 1'b0, 1'b1, 1'b0);
        check_eq("jalr_f_iret", 32'(instret), 32'd6);
        cyc(OPC_JALR, 1'b0, 1'b0, 1'b0);
        cyc(OPC_JALR, 1'b0, 1'b0, 1'b0);
        cyc(OPC_JALR, 1'b0, 1'b0, 1'b0);
        check_eq("jalr_w_pcsel", 32'(pc_sel), 32'(PC_ALU));
        check_eq("jalr_w_wbsel", 32'(wb_sel), 32'(WB_PC4));

        // lui retires the 8th instruction: the 3-bit counter wraps to 0
        cyc(OPC_LUI, 1'b0, 1'b1, 1'b0);
        check_eq("lui_f_iret", 32'(instret), 32'd7);
        cyc(OPC_LUI, 1'b0, 1'b0, 1'b0);
        cyc(OPC_LUI, 1'b0, 1'b0, 1'b0);
        check_eq("lui_e_asel", 32'(alu_a_sel), 32'(A_ZERO));
        check_eq("lui_e_bsel", 32'(alu_b_sel), 32'(B_IMM));
        cyc(OPC_LUI, 1'b0, 1'b0, 1'b0);
        check_eq("lui_w_pcsel", 32'(pc_sel), 32'(PC_PLUS4));

        // addi then lw interrupted by an asynchronous reset in MEM
        run_plain(OPC_OP_IMM);
        cyc(OPC_LOAD, 1'b0, 1'b1, 1'b0);
        check_eq("wrap_iret", 32'(instret), 32'd1);
        cyc(OPC_LOAD, 1'b0, 1'b0, 1'b0);
        cyc(OPC_LOAD, 1'b0, 1'b0, 1'b0);
        cyc(OPC_LOAD, 1'b0, 1'b0, 1'b0);
        check_eq("arst_pre_req", 32'(dmem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_req",   32'(dmem_req), 32'd0);
        check_eq("arst_state", 32'(state),    32'(ST_FETCH));
        check_eq("arst_iret",  32'(instret),  32'd0);

        // addi then an illegal opcode halts without retiring
        run_plain(OPC_OP_IMM);
        cyc(OPC_ILLEGAL, 1'b0, 1'b1, 1'b0);
        check_eq("ill_f_iret", 32'(instret), 32'd1);
        cyc(OPC_ILLEGAL, 1'b0, 1'b1, 1'b0);
        check_eq("ill_d_state", 32'(state), 32'(ST_DECODE));
        for (int i = 0; i < 3; i++) begin
            cyc(OPC_ILLEGAL, 1'b0, 1'b1, 1'b1);
            check_eq("ill_h_state",  32'(state),      32'(ST_HALT));
            check_eq("ill_h_halted", 32'(halted),     32'd1);
            check_eq("ill_h_cause",  32'(halt_cause), 32'(HC_ILLEGAL));
            check_eq("ill_h_req",    32'(imem_req),   32'd0);
            check_eq("ill_h_iret",   32'(instret),    32'd1);
        end

        // fetch timeout: no ack for four cycles
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(OPC_OP, 1'b0, 1'b0, 1'b0);
            check_eq("to_w_req",    32'(imem_req), 32'd1);
            check_eq("to_w_halted", 32'(halted),   32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(OPC_OP, 1'b0, 1'b0, 1'b0);
            check_eq("to_h_state",  32'(state),      32'(ST_HALT));
            check_eq("to_h_halted", 32'(halted),     32'd1);
            check_eq("to_h_cause",  32'(halt_cause), 32'(HC_TIMEOUT));
            check_eq("to_h_req",    32'(imem_req),   32'd0);
        end

        // ack on the limit cycle wins, then SYSTEM halts unretired
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(OPC_SYSTEM, 1'b0, 1'b0, 1'b0);
        end
        cyc(OPC_SYSTEM, 1'b0, 1'b1, 1'b0);
        check_eq("lim_irwe", 32'(ir_we), 32'd1);
        cyc(OPC_SYSTEM, 1'b0, 1'b0, 1'b0);
        check_eq("lim_state",  32'(state),  32'(ST_DECODE));
        check_eq("lim_halted", 32'(halted), 32'd0);
        cyc(OPC_SYSTEM, 1'b0, 1'b0, 1'b0);
        check_eq("sys_e_state", 32'(state), 32'(ST_EXECUTE));
        cyc(OPC_SYSTEM, 1'b0, 1'b1, 1'b1);
        check_eq("sys_h_state", 32'(state),      32'(ST_HALT));
        check_eq("sys_h_cause", 32'(halt_cause), 32'(HC_SYSTEM));
        check_eq("sys_h_iret",  32'(instret),    32'd0);
        check_eq("sys_h_pcwe",  32'(pc_we),      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
